twi_regfile_slave: RTL and testbench

Parametrised successor to the single-register `twi_slave2`. It is an I2C/TWI slave holding a bank of NREGS 8-bit registers behind one 7-bit address, reached through an auto-incrementing register pointer. Unlike its predecessor it is fully synchronous to the system clock: SCL and SDA are oversampled, synchronised and glitch-filtered rather than used as clocks. It sits in `top` beside the other slaves, and its `sdaLow` is OR-ed into `hostSdaOutEn`.

---
 rtl/twi_pkg.sv | 24 ++
 rtl/twi_filter.sv | 40 ++++
 rtl/twi_regfile_slave.sv | 168 ++++++++++++++++
 tb/tb_twi_regfile_slave.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/twi_pkg.sv
// rtl/twi_pkg.sv - shared TWI state encodings, bus constants and helpers
package twi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_PTR,
        ST_WR,
        ST_RD,
        ST_MACK,
        ST_IGNORE
    } twi_state_t;

    // Released open-drain lines read high, so filters and edge detectors reset to this level.
    localparam logic       BUS_IDLE = 1'b1;
    localparam logic [3:0] LAST_BIT = 4'd7;
    localparam logic [3:0] ACK_SLOT = 4'd8;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/twi_filter.sv
// rtl/twi_filter.sv - two-flop synchroniser plus FILT-sample stability filter
module twi_filter
    import twi_pkg::*;
#(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // dout only follows s2 after FILT consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= BUS_IDLE;
            s2   <= BUS_IDLE;
            dout <= BUS_IDLE;
            cnt  <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT - 1)) begin
                dout <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/twi_regfile_slave.sv
// rtl/twi_regfile_slave.sv - oversampled TWI slave with an auto-incrementing register bank
module twi_regfile_slave
    import twi_pkg::*;
#(
    parameter logic [6:0]           ADDR  = 7'h55,
    parameter int                   NREGS = 4,
    parameter logic [8*NREGS-1:0]   INIT  = '0,
    parameter int                   FILT  = 3,
    localparam int                  PW    = ptr_width(NREGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scl,
    input  logic               sda,
    output logic               sdaLow,
    output logic [8*NREGS-1:0] regs,
    output logic               wrStb,
    output logic [PW-1:0]      wrIdx,
    output logic               busy
);

    logic scl_f, sda_f, scl_q, sda_q;
    logic start_det, stop_det, scl_rise, scl_fall;

    twi_filter #(.FILT(FILT)) u_scl_filt (.clk(clk), .rst_n(rst_n), .din(scl), .dout(scl_f));
    twi_filter #(.FILT(FILT)) u_sda_filt (.clk(clk), .rst_n(rst_n), .din(sda), .dout(sda_f));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= BUS_IDLE;
            sda_q <= BUS_IDLE;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    // START/STOP look only at the current SCL level so they win over a coincident SCL edge.
    assign start_det = scl_f & sda_q & ~sda_f;
    assign stop_det  = scl_f & ~sda_q & sda_f;
    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;

    twi_state_t    state;
    logic [3:0]    bit_cnt;
    logic [6:0]    shift;
    logic          rw;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [7:0]    mem [NREGS];
    logic [7:0]    rx_byte;
    logic [7:0]    cur_byte;
    logic          tx_bit;
    logic          drive_low;

    assign rx_byte  = {shift, sda_f};
    assign cur_byte = mem[ptr];
    assign tx_bit   = cur_byte[3'(LAST_BIT - bit_cnt)];
    assign ptr_next = (ptr == PW'(NREGS - 1)) ? '0 : ptr + PW'(1);

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
        assign regs[8*gi +: 8] = mem[gi];
    end

    // Level to present on SDA for the SCL cycle that starts at the next falling edge.
    always_comb begin
        drive_low = 1'b0;
        case (state)
            ST_ACK_A:     drive_low = 1'b1;
            ST_PTR, ST_WR: drive_low = (bit_cnt == ACK_SLOT);
            ST_RD:        drive_low = ~tx_bit;
            default:      drive_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            rw      <= 1'b0;
            ptr     <= '0;
            sdaLow  <= 1'b0;
            wrStb   <= 1'b0;
            wrIdx   <= '0;
            busy    <= 1'b0;
            for (int i = 0; i < NREGS; i++) mem[i] <= INIT[8*i +: 8];
        end else begin
            wrStb <= 1'b0;
            if (stop_det) begin
                state  <= ST_IDLE;
                busy   <= 1'b0;
                sdaLow <= 1'b0;
            end else if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= '0;
                sdaLow  <= 1'b0;
            end else if (scl_fall) begin
                sdaLow <= drive_low;
            end else if (scl_rise) begin
                case (state)
                    ST_ADDR: begin
                        shift   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (rx_byte[7:1] == ADDR) begin
                                state <= ST_ACK_A;
                                rw    <= rx_byte[0];
                                busy  <= 1'b1;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ACK_A: begin
                        bit_cnt <= '0;
                        state   <= rw ? ST_RD : ST_PTR;
                    end
                    ST_PTR: begin
                        if (bit_cnt == ACK_SLOT) begin
                            bit_cnt <= '0;
                            state   <= ST_WR;
                        end else begin
                            shift   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == LAST_BIT) begin
                                if (rx_byte < 8'(NREGS)) ptr <= rx_byte[PW-1:0];
                                else                     state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_WR: begin
                        if (bit_cnt == ACK_SLOT) begin
                            bit_cnt <= '0;
                            ptr     <= ptr_next;
                        end else begin
                            shift   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == LAST_BIT) begin
                                mem[ptr] <= rx_byte;
                                wrStb    <= 1'b1;
                                wrIdx    <= ptr;
                            end
                        end
                    end
                    ST_RD: begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= ST_MACK;
                        end
                    end
                    ST_MACK: begin
                        if (sda_f) begin
                            state <= ST_IGNORE;
                        end else begin
                            ptr   <= ptr_next;
                            state <= ST_RD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_twi_regfile_slave.sv
// tb/tb_twi_regfile_slave.sv - scoreboard bench with an I2C master model and register-bank reference
module tb_twi_regfile_slave;

    localparam logic [6:0]  ADDR  = 7'h55;
    localparam int          NREGS = 4;
    localparam int          PW    = 2;
    localparam logic [31:0] INIT  = {8'h44, 8'h33, 8'h22, 8'h11};
    localparam int          T     = 6;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 scl   = 1'b1;
    logic                 sda_m = 1'b1;
    logic                 sda;
    logic                 sdaLow;
    logic [8*NREGS-1:0]   regs;
    logic                 wrStb;
    logic [PW-1:0]        wrIdx;
    logic                 busy;

    assign sda = sda_m & ~sdaLow;

    twi_regfile_slave #(.ADDR(ADDR), .NREGS(NREGS), .INIT(INIT), .FILT(3)) dut (
        .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda), .sdaLow(sdaLow),
        .regs(regs), .wrStb(wrStb), .wrIdx(wrIdx), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_regs [NREGS];
    int         m_ptr;
    logic [7:0] exp_rd[$];
    bit         exp_ack[$];
    int         exp_wr_idx[$];
    logic [7:0] exp_wr_dat[$];
    logic [7:0] rd_obs;
    bit         ack_obs;
    event       rd_ev, ack_ev;
    bit         glitch = 1'b0;
    bit         watch = 1'b0, saw_low = 1'b0, saw_busy = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_unexp(string name, logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = INIT[8*i +: 8];
        m_ptr = 0;
    endfunction

    // Monitors: compare every DUT-presented result against the oldest expectation.
    initial forever begin
        @(rd_ev);
        if (exp_rd.size() == 0) fail_unexp("rd_unexpected", rd_obs);
        else check("rd_data", rd_obs, exp_rd.pop_front());
    end

    initial forever begin
        @(ack_ev);
        if (exp_ack.size() == 0) fail_unexp("ack_unexpected", ack_obs);
        else check("ack", ack_obs, exp_ack.pop_front());
    end

    always @(negedge clk) begin
        if (rst_n && wrStb) begin
            if (exp_wr_idx.size() == 0) begin
                fail_unexp("wr_unexpected", wrIdx);
            end else begin
                int idx;
                idx = exp_wr_idx.pop_front();
                check("wr_idx", wrIdx, idx);
                check("wr_data", regs[8*idx +: 8], exp_wr_dat.pop_front());
            end
        end
        if (watch) begin
            if (sdaLow) saw_low = 1'b1;
            if (busy)   saw_busy = 1'b1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clock_bit(input bit b, output bit s);
        sda_m = b;
        tick(T);
        scl = 1'b1;
        tick(T);
        #1 s = sda;
        if (glitch) begin
            tick(2); scl = 1'b0; tick(1); scl = 1'b1; tick(T - 3);
        end else begin
            tick(T);
        end
        scl = 1'b0;
        if (glitch) begin
            tick(2); scl = 1'b1; tick(1); scl = 1'b0; tick(T - 3);
        end else begin
            tick(T);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(T);
        scl = 1'b1;   tick(T);
        sda_m = 1'b0; tick(T);
        scl = 1'b0;   tick(T);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(T);
        scl = 1'b1;   tick(T);
        sda_m = 1'b1; tick(2 * T);
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ackd);
        bit s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ackd    = ~s;
        ack_obs = ackd;
        -> ack_ev;
    endtask

    task automatic read_byte(input bit mack, output logic [7:0] d);
        bit s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(~mack, s);
        rd_obs = d;
        -> rd_ev;
    endtask

    task automatic do_write(input int p, input logic [7:0] data[$], input bit stop_at_end);
        bit a;
        i2c_start();
        exp_ack.push_back(1'b1);
        write_byte({ADDR, 1'b0}, a);
        if (p < NREGS) begin
            exp_ack.push_back(1'b1);
            write_byte(8'(p), a);
            m_ptr = p;
            foreach (data[k]) begin
                exp_ack.push_back(1'b1);
                exp_wr_idx.push_back(m_ptr);
                exp_wr_dat.push_back(data[k]);
                m_regs[m_ptr] = data[k];
                m_ptr = (m_ptr + 1) % NREGS;
                write_byte(data[k], a);
            end
        end else begin
            exp_ack.push_back(1'b0);
            write_byte(8'(p), a);
        end
        if (stop_at_end) begin
            i2c_stop();
            #1 check("busy_after_stop", busy, 0);
        end
    endtask

    task automatic do_read(input int n);
        bit a;
        logic [7:0] d;
        i2c_start();
        exp_ack.push_back(1'b1);
        write_byte({ADDR, 1'b1}, a);
        #1 check("busy_matched", busy, 1);
        for (int k = 0; k < n; k++) begin
            exp_rd.push_back(m_regs[m_ptr]);
            read_byte(k < n - 1, d);
            if (k < n - 1) m_ptr = (m_ptr + 1) % NREGS;
        end
        i2c_stop();
        #1 check("busy_after_stop", busy, 0);
    endtask

    initial begin
        logic [7:0] dq[$];
        int  op, n;
        bit  a, s, got_low;

        model_reset();
        tick(5);
        #1;
        check("rst_sdaLow", sdaLow, 0);
        check("rst_wrStb", wrStb, 0);
        check("rst_wrIdx", wrIdx, 0);
        check("rst_busy", busy, 0);
        check("rst_regs", regs, INIT);
        @(negedge clk) rst_n = 1'b1;
        tick(20);

        // Read all registers and wrap to index 0.
        do_read(5);

        // Pointer 2, two data bytes, then a read that starts at the wrapped pointer.
        dq = {8'hAA, 8'hBB};
        do_write(2, dq, 1'b1);
        check("regs_after_wr", regs, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
        do_read(1);

        // Out-of-range pointer is NACKed and leaves the pointer alone.
        dq.delete();
        do_write(5, dq, 1'b1);
        do_read(2);

        // Foreign address: never drive SDA, never go busy.
        saw_low = 1'b0; saw_busy = 1'b0; watch = 1'b1;
        i2c_start();
        exp_ack.push_back(1'b0);
        write_byte({7'h44, 1'b0}, a);
        exp_ack.push_back(1'b0);
        write_byte(8'h12, a);
        i2c_stop();
        watch = 1'b0;
        check("foreign_sdaLow", saw_low, 0);
        check("foreign_busy", saw_busy, 0);

        // SCL glitches during data bytes.
        glitch = 1'b1;
        dq = {8'h5A, 8'hC3};
        do_write(1, dq, 1'b1);
        glitch = 1'b0;
        do_read(3);

        // STOP in the middle of a data byte: no commit.
        i2c_start();
        exp_ack.push_back(1'b1);
        write_byte({ADDR, 1'b0}, a);
        exp_ack.push_back(1'b1);
        write_byte(8'd3, a);
        m_ptr = 3;
        for (int i = 0; i < 4; i++) clock_bit(i[0], s);
        i2c_stop();
        #1 check("abort_busy", busy, 0);
        do_read(2);

        // Random mix of writes, reads and pointer-write + repeated-START reads.
        for (int it = 0; it < 14; it++) begin
            op = $urandom_range(0, 2);
            dq.delete();
            if (op == 0) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
                do_write($urandom_range(0, 5), dq, 1'b1);
            end else if (op == 1) begin
                do_read($urandom_range(1, 4));
            end else begin
                do_write($urandom_range(0, NREGS - 1), dq, 1'b0);
                do_read($urandom_range(1, 3));
            end
        end

        // Reset while the slave is driving a read bit low.
        dq = {8'h00};
        do_write(0, dq, 1'b1);
        dq.delete();
        do_write(0, dq, 1'b1);
        i2c_start();
        exp_ack.push_back(1'b1);
        write_byte({ADDR, 1'b1}, a);
        got_low = 1'b0;
        for (int i = 0; i < 4 * T && !got_low; i++) begin
            @(negedge clk);
            got_low = sdaLow;
        end
        check("sdaLow_before_reset", got_low, 1);
        #2 rst_n = 1'b0;
        #1;
        check("sdaLow_async_reset", sdaLow, 0);
        check("regs_after_reset", regs, INIT);
        check("busy_after_reset", busy, 0);
        scl = 1'b1;
        sda_m = 1'b1;
        tick(4);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        tick(20);
        do_read(4);

        tick(10);
        check("rd_queue_drained", exp_rd.size(), 0);
        check("ack_queue_drained", exp_ack.size(), 0);
        check("wr_queue_drained", exp_wr_idx.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
